// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: opcodes and FSM state encoding shared by the ALU arbiter
package alu_arb_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester channels plus the tagged response channel
interface alu_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [WIDTH-1:0] rsp_result;
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_core_32.sv
// alu_core_32: combinational AND/OR/ADD/SUB/signed-SLT unit
module alu_core_32 import alu_arb_pkg::*; #(parameter int WIDTH = 32) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  logic [WIDTH-1:0] diff;
  logic             lt;
  always_comb begin
    diff = a - b;
    // differing signs decide directly, so a wrapped difference never misleads
    lt = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];
    result = (op == OP_AND) ? (a & b) :
             (op == OP_OR)  ? (a | b) :
             (op == OP_ADD) ? (a + b) :
             (op == OP_SUB) ? diff :
             (op == OP_SLT) ? {{(WIDTH-1){1'b0}}, lt} : '0;
    zero = (result == '0);
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters,
// with a registered, id-tagged response channel
module alu_arbiter import alu_arb_pkg::*; #(parameter int WIDTH = 32) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  state_t           state_q, state_d;
  logic             last_q, last_d, id_q, id_d, rid_q, rid_d, zero_q, zero_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_res;
  logic             alu_zero, idle, gnt0, gnt1, take, load;
  alu_core_32 #(.WIDTH(WIDTH)) u_alu (
    .op(op_q), .a(a_q), .b(b_q), .result(alu_res), .zero(alu_zero)
  );
  always_comb begin
    idle  = (state_q == IDLE);
    // on a tie, the requester that was not granted last time wins
    gnt1  = bus.req1_valid & (~bus.req0_valid | ~last_q);
    gnt0  = bus.req0_valid & ~gnt1;
    take  = idle & (gnt0 | gnt1);
    load  = (state_q == EXEC);
    state_d = idle ? (take ? EXEC : IDLE) : load ? RESP : (bus.rsp_ready ? IDLE : RESP);
    last_d  = take ? gnt1 : last_q;
    id_d    = take ? gnt1 : id_q;
    op_d    = take ? (gnt1 ? bus.req1_op : bus.req0_op) : op_q;
    a_d     = take ? (gnt1 ? bus.req1_a : bus.req0_a) : a_q;
    b_d     = take ? (gnt1 ? bus.req1_b : bus.req0_b) : b_q;
    res_d   = load ? alu_res : res_q;
    zero_d  = load ? alu_zero : zero_q;
    rid_d   = load ? id_q : rid_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      rid_q   <= rid_d;
    end
  end
  assign bus.req0_ready = idle & gnt0;
  assign bus.req1_ready = idle & gnt1;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_id     = rid_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for the shared-ALU arbiter
module tb_alu_arbiter;
  import alu_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_pass = 0, cyc = 0, acc_cyc = 0;
  bit   acc0 = 0, acc1 = 0, prev_rv = 0;
  logic [31:0] exp_res_q[$];
  bit          exp_id_q[$];
  bit          order_q[$];
  alu_arbiter_if #(.WIDTH(32)) bus ();
  alu_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction
  always @(negedge clk) if (!rst) begin
    cyc++;
    if (bus.req0_valid && bus.req1_valid) chk("onehot_ready", {31'b0, bus.req0_ready & bus.req1_ready}, 0);
    if (bus.req0_valid && bus.req0_ready) begin
      exp_res_q.push_back(model(bus.req0_op, bus.req0_a, bus.req0_b));
      exp_id_q.push_back(1'b0);
      acc0 = 1; acc_cyc = cyc;
    end
    if (bus.req1_valid && bus.req1_ready) begin
      exp_res_q.push_back(model(bus.req1_op, bus.req1_a, bus.req1_b));
      exp_id_q.push_back(1'b1);
      acc1 = 1; acc_cyc = cyc;
    end
    if (bus.rsp_valid && !prev_rv) chk("latency", cyc - acc_cyc, 2);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_res_q.size() == 0) chk("spurious_rsp", 1, 0);
      else begin
        logic [31:0] r;
        r = exp_res_q.pop_front();
        chk("result", bus.rsp_result, r);
        chk("id", {31'b0, bus.rsp_id}, {31'b0, exp_id_q.pop_front()});
        chk("zero", {31'b0, bus.rsp_zero}, {31'b0, r == 0});
        order_q.push_back(bus.rsp_id);
      end
    end
    prev_rv = bus.rsp_valid;
  end
  task automatic set0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1;
  endtask
  task automatic set1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1;
  endtask
  task automatic step();
    @(posedge clk); #1;
    if (acc0) begin bus.req0_valid = 0; acc0 = 0; end
    if (acc1) begin bus.req1_valid = 0; acc1 = 0; end
  endtask
  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      step();
      if (!bus.req0_valid && !bus.req1_valid && exp_res_q.size() == 0) return;
    end
    chk("drain_timeout", 1, 0);
    bus.req0_valid = 0; bus.req1_valid = 0;
  endtask
  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.rsp_valid}, 0);
    chk({tag, "_result"}, bus.rsp_result, 0);
    chk({tag, "_id"}, {31'b0, bus.rsp_id}, 0);
    chk({tag, "_zero"}, {31'b0, bus.rsp_zero}, 0);
  endtask
  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
    bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    #2 check_quiet("reset");
    @(posedge clk); #1 rst = 0;
    // arbitration from reset: req0 wins first tie, then alternation
    set0(OP_ADD, 32'd1, 32'd2); set1(OP_SUB, 32'd0, 32'd1);
    drain();
    set0(OP_ADD, 32'd1, 32'd2); set1(OP_SUB, 32'd0, 32'd1);
    drain();
    chk("order_len", order_q.size(), 4);
    if (order_q.size() == 4) for (int i = 0; i < 4; i++) chk($sformatf("order%0d", i), {31'b0, order_q[i]}, i % 2);
    // signed compare, including overflowing differences
    set0(OP_SLT, 32'd7, 32'd32); drain();
    set0(OP_SLT, 32'd5, 32'd4); drain();
    set0(OP_SLT, 32'd5, 32'hFFFFFFFD); drain();
    set0(OP_SLT, 32'hFFFFFFFC, 32'hFFFFFFFD); drain();
    set0(OP_SLT, 32'h80000000, 32'd1); drain();
    set0(OP_SLT, 32'h7FFFFFFF, 32'h80000000); drain();
    set1(OP_OR, 32'h12340000, 32'h00005678); drain();
    // backpressure: response must hold while the consumer stalls
    bus.rsp_ready = 0;
    set0(OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) step();
    chk("bp_reached", {31'b0, bus.rsp_valid}, 1);
    set1(OP_ADD, 32'd3, 32'd4);
    set0(OP_OR, 32'd1, 32'd2);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, bus.rsp_valid}, 1);
      chk("bp_result", bus.rsp_result, 32'h00F000F0);
      chk("bp_id", {31'b0, bus.rsp_id}, 0);
      chk("bp_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 0);
    end
    @(posedge clk); #1 bus.rsp_ready = 1;
    drain();
    // zero flag and undefined opcode
    set0(OP_SUB, 32'd9, 32'd9); drain();
    set1(3'b011, 32'hDEAD, 32'hBEEF); drain();
    set0(OP_ADD, 32'd10, 32'd20); drain();
    // reset while an op sits in EXEC
    set0(OP_ADD, 32'd5, 32'd6);
    for (int i = 0; i < 10 && bus.req0_valid; i++) step();
    rst = 1;
    #1 check_quiet("midrst");
    chk("midrst_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 0);
    exp_res_q.delete(); exp_id_q.delete(); order_q.delete();
    prev_rv = 0;
    #2 rst = 0;
    set0(OP_ADD, 32'd1, 32'd1); set1(OP_OR, 32'd2, 32'd1);
    drain();
    chk("post_rst_len", order_q.size(), 2);
    if (order_q.size() == 2) begin
      chk("post_rst_first", {31'b0, order_q[0]}, 0);
      chk("post_rst_second", {31'b0, order_q[1]}, 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
